// File: rtl/phy_speed_monitor.sv
// MDIO poller: periodically reads a PHY status register and decodes link, speed and duplex.
// Defining PHY_SPEED_MON_CHANGE_IRQ_EN adds irq_ack/change_irq for status-change interrupts.
module phy_speed_monitor #(
  parameter int         MDC_DIV     = 10,
  parameter logic [4:0] PHY_ADDR    = 5'd0,
  parameter logic [4:0] STATUS_REG  = 5'd17,
  parameter int         POLL_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mdio_in,
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
  input  logic        irq_ack,
  output logic        change_irq,
`endif
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic        eth_mode,
  output logic        ena_10,
  output logic        link_up,
  output logic        full_duplex,
  output logic        busy,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        no_ack
);

  localparam int                WAIT_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_CYCLES - 1);
  localparam logic [7:0]        DIV_LAST  = 8'(MDC_DIV - 1);
  localparam logic [13:0]       CMD_WORD  = {2'b01, 2'b10, PHY_ADDR, STATUS_REG};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_CMD, S_TA, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       shift_q, shift_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              ta_bad_q, ta_bad_d;
  logic              mdc_q, mdc_d;
  logic              mdio_out_q, mdio_out_d;
  logic              mdio_oen_q, mdio_oen_d;
  logic              eth_mode_q, eth_mode_d;
  logic              ena_10_q, ena_10_d;
  logic              link_up_q, link_up_d;
  logic              full_duplex_q, full_duplex_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              no_ack_q, no_ack_d;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
  logic              change_irq_q, change_irq_d;
`endif

  logic in_frame, tick, mdc_rise, mdc_fall;

  assign in_frame = (state_q == S_PRE) || (state_q == S_CMD) ||
                    (state_q == S_TA)  || (state_q == S_DATA);
  assign tick     = in_frame && (div_cnt_q == DIV_LAST);
  assign mdc_rise = tick && !mdc_q;
  assign mdc_fall = tick && mdc_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    shift_d       = shift_q;
    rd_data_d     = rd_data_q;
    ta_bad_d      = ta_bad_q;
    mdc_d         = mdc_q;
    mdio_out_d    = mdio_out_q;
    mdio_oen_d    = mdio_oen_q;
    eth_mode_d    = eth_mode_q;
    ena_10_d      = ena_10_q;
    link_up_d     = link_up_q;
    full_duplex_d = full_duplex_q;
    no_ack_d      = no_ack_q;
    rd_valid_d    = 1'b0;

    if (in_frame) begin
      if (tick) begin
        mdc_d     = ~mdc_q;
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_PRE;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          mdc_d      = 1'b0;
          mdio_out_d = 1'b1;
          mdio_oen_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_PRE;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          mdc_d      = 1'b0;
          mdio_out_d = 1'b1;
          mdio_oen_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_PRE: begin
        if (mdc_fall) begin
          if (bit_cnt_q == 5'd31) begin
            state_d    = S_CMD;
            bit_cnt_d  = '0;
            mdio_out_d = CMD_WORD[13];
          end else begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            mdio_out_d = 1'b1;
          end
        end
      end
      S_CMD: begin
        if (mdc_fall) begin
          if (bit_cnt_q == 5'd13) begin
            state_d    = S_TA;
            bit_cnt_d  = '0;
            mdio_out_d = 1'b1;
            mdio_oen_d = 1'b1;
          end else begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            mdio_out_d = CMD_WORD[4'd12 - bit_cnt_q[3:0]];
          end
        end
      end
      S_TA: begin
        // Only the second turnaround bit is meaningful: the PHY must pull it low.
        if (mdc_rise && (bit_cnt_q == 5'd1)) begin
          ta_bad_d = mdio_in;
        end
        if (mdc_fall) begin
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = '0;
            if (ta_bad_q) begin
              state_d  = S_DONE;
              no_ack_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (mdc_rise) begin
          shift_d = {shift_q[14:0], mdio_in};
        end
        if (mdc_fall) begin
          if (bit_cnt_q == 5'd15) begin
            state_d    = S_DONE;
            bit_cnt_d  = '0;
            rd_valid_d = 1'b1;
            rd_data_d  = shift_q;
            no_ack_d   = 1'b0;
            link_up_d  = shift_q[10];
            if (shift_q[11]) begin
              full_duplex_d = shift_q[13];
              case (shift_q[15:14])
                2'b10:   begin eth_mode_d = 1'b1; ena_10_d = 1'b0; end
                2'b01:   begin eth_mode_d = 1'b0; ena_10_d = 1'b0; end
                2'b00:   begin eth_mode_d = 1'b0; ena_10_d = 1'b1; end
                default: ;
              endcase
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      S_DONE: begin
        state_d    = enable ? S_WAIT : S_IDLE;
        wait_cnt_d = '0;
        bit_cnt_d  = '0;
        div_cnt_d  = '0;
        mdc_d      = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_WAIT);

`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
    change_irq_d = change_irq_q & ~irq_ack;
    if (rd_valid_d && ((link_up_d != link_up_q) || (eth_mode_d != eth_mode_q) ||
                       (ena_10_d != ena_10_q))) begin
      change_irq_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      shift_q       <= '0;
      rd_data_q     <= '0;
      ta_bad_q      <= 1'b0;
      mdc_q         <= 1'b0;
      mdio_out_q    <= 1'b1;
      mdio_oen_q    <= 1'b1;
      eth_mode_q    <= 1'b0;
      ena_10_q      <= 1'b0;
      link_up_q     <= 1'b0;
      full_duplex_q <= 1'b0;
      busy_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      no_ack_q      <= 1'b0;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
      change_irq_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      shift_q       <= shift_d;
      rd_data_q     <= rd_data_d;
      ta_bad_q      <= ta_bad_d;
      mdc_q         <= mdc_d;
      mdio_out_q    <= mdio_out_d;
      mdio_oen_q    <= mdio_oen_d;
      eth_mode_q    <= eth_mode_d;
      ena_10_q      <= ena_10_d;
      link_up_q     <= link_up_d;
      full_duplex_q <= full_duplex_d;
      busy_q        <= busy_d;
      rd_valid_q    <= rd_valid_d;
      no_ack_q      <= no_ack_d;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
      change_irq_q  <= change_irq_d;
`endif
    end
  end

  assign mdc         = mdc_q;
  assign mdio_out    = mdio_out_q;
  assign mdio_oen    = mdio_oen_q;
  assign eth_mode    = eth_mode_q;
  assign ena_10      = ena_10_q;
  assign link_up     = link_up_q;
  assign full_duplex = full_duplex_q;
  assign busy        = busy_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign no_ack      = no_ack_q;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
  assign change_irq  = change_irq_q;
`endif

endmodule

// File: tb/tb_phy_speed_monitor.sv
// Bench for phy_speed_monitor: MDIO PHY model feeding a response queue, scoreboard checked at frame end.
// Builds with or without PHY_SPEED_MON_CHANGE_IRQ_EN.
module tb_phy_speed_monitor;
  localparam int MDC_DIV   = 2;
  localparam int POLL      = 100;
  localparam int FRAME_LEN = 64 * 2 * MDC_DIV + 1;
  localparam logic [45:0] EXP_HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd0, 5'd17};

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mdio_in = 1'b1;
  logic        mdc, mdio_out, mdio_oen, eth_mode, ena_10, link_up, full_duplex;
  logic        busy, rd_valid, no_ack;
  logic [15:0] rd_data;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
  logic        irq_ack;
  logic        change_irq;
`endif

  always #5 clk = ~clk;

  phy_speed_monitor #(
    .MDC_DIV(MDC_DIV), .PHY_ADDR(5'd0), .STATUS_REG(5'd17), .POLL_CYCLES(POLL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mdio_in(mdio_in),
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
    .irq_ack(irq_ack), .change_irq(change_irq),
`endif
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oen(mdio_oen), .eth_mode(eth_mode),
    .ena_10(ena_10), .link_up(link_up), .full_duplex(full_duplex), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .no_ack(no_ack)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        ack;
  } resp_t;

  resp_t stim_q[$];
  resp_t exp_q[$];
  resp_t cur;

  int total = 0;
  int bad = 0;
  int frames_done = 0;
  int rise_cnt = 0;
  int busy_len = 0;
  int vld_cnt = 0;
  int idle_cnt = 0;
  logic gap_arm = 1'b0;
  logic busy_prev = 1'b0;
  logic mdc_prev = 1'b0;
  logic hdr_oen_bad = 1'b0;
  logic [45:0] hdr = '0;
  logic m_link = 1'b0, m_eth = 1'b0, m_ena = 1'b0, m_fd = 1'b0, m_noack = 1'b0, m_irq = 1'b0;
  logic [15:0] m_rd = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic frame_end();
    resp_t e;
    logic  o_link, o_eth, o_ena;
    check_val("exp_q_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    o_link = m_link; o_eth = m_eth; o_ena = m_ena;
    if (e.ack) begin
      m_rd = e.data;
      m_link = e.data[10];
      m_noack = 1'b0;
      if (e.data[11]) begin
        m_fd = e.data[13];
        case (e.data[15:14])
          2'b10:   begin m_eth = 1'b1; m_ena = 1'b0; end
          2'b01:   begin m_eth = 1'b0; m_ena = 1'b0; end
          2'b00:   begin m_eth = 1'b0; m_ena = 1'b1; end
          default: ;
        endcase
      end
      if ((o_link != m_link) || (o_eth != m_eth) || (o_ena != m_ena)) m_irq = 1'b1;
      check_val("vld_pulses", 64'(vld_cnt), 64'd1);
      check_val("busy_len", 64'(busy_len), 64'(FRAME_LEN));
    end else begin
      m_noack = 1'b1;
      check_val("vld_pulses", 64'(vld_cnt), 64'd0);
    end
    $display("frame %0d phy=%h ack=%0d rd_data=%h link=%0d eth=%0d ena10=%0d fd=%0d no_ack=%0d",
             frames_done, e.data, e.ack, rd_data, link_up, eth_mode, ena_10, full_duplex, no_ack);
    check_val("rd_data", 64'(rd_data), 64'(m_rd));
    check_val("no_ack", 64'(no_ack), 64'(m_noack));
    check_val("link_up", 64'(link_up), 64'(m_link));
    check_val("eth_mode", 64'(eth_mode), 64'(m_eth));
    check_val("ena_10", 64'(ena_10), 64'(m_ena));
    check_val("full_duplex", 64'(full_duplex), 64'(m_fd));
    check_val("speed_excl", 64'(eth_mode & ena_10), 64'd0);
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
    check_val("change_irq", 64'(change_irq), 64'(m_irq));
`endif
    frames_done++;
  endtask

  // PHY model and frame monitor: drives mdio_in between MDC rises, captures the header.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      rise_cnt = 0; busy_prev = 1'b0; mdc_prev = 1'b0; mdio_in = 1'b1;
      gap_arm = 1'b0; idle_cnt = 0;
      m_link = 1'b0; m_eth = 1'b0; m_ena = 1'b0; m_fd = 1'b0; m_noack = 1'b0;
      m_irq = 1'b0; m_rd = '0;
    end else begin
      if (busy && !busy_prev) begin
        if (gap_arm) check_val("poll_gap", 64'(idle_cnt), 64'(POLL));
        if (stim_q.size() > 0) cur = stim_q.pop_front();
        else cur = '{data: 16'h0000, ack: 1'b1};
        exp_q.push_back(cur);
        rise_cnt = 0; hdr = '0; hdr_oen_bad = 1'b0; vld_cnt = 0; busy_len = 0;
        mdio_in = 1'b1;
      end
      if (busy) begin
        busy_len++;
        if (rd_valid) vld_cnt++;
      end
      if (busy && mdc && !mdc_prev) begin
        if (rise_cnt < 46) begin
          hdr[45 - rise_cnt] = mdio_out;
          if (mdio_oen !== 1'b0) hdr_oen_bad = 1'b1;
        end else if (rise_cnt == 46) begin
          check_val("header", 64'(hdr), 64'(EXP_HDR));
          check_val("header_oen", 64'(hdr_oen_bad), 64'd0);
          check_val("ta_oen", 64'(mdio_oen), 64'd1);
        end
        rise_cnt++;
        if (rise_cnt == 47) mdio_in = cur.ack ? 1'b0 : 1'b1;
        else if (rise_cnt >= 48 && rise_cnt <= 63) mdio_in = cur.data[63 - rise_cnt];
        else mdio_in = 1'b1;
      end
      if (!busy && busy_prev) begin
        frame_end();
        mdio_in = 1'b1;
        idle_cnt = 0;
        gap_arm = enable;
      end
      if (!busy) begin
        idle_cnt++;
        if (!enable) gap_arm = 1'b0;
      end
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
      if (irq_ack) m_irq = 1'b0;
`endif
      busy_prev = busy;
      mdc_prev = mdc;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("frames_reached", 64'(frames_done), 64'(n));
  endtask

  task automatic wait_rise(input int n, input int budget);
    int k = 0;
    while (!busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    while (rise_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("rise_reached", 64'(rise_cnt >= n), 64'd1);
  endtask

  task automatic check_reset_values();
    check_val("rst_mdc", 64'(mdc), 64'd0);
    check_val("rst_mdio_out", 64'(mdio_out), 64'd1);
    check_val("rst_mdio_oen", 64'(mdio_oen), 64'd1);
    check_val("rst_eth_mode", 64'(eth_mode), 64'd0);
    check_val("rst_ena_10", 64'(ena_10), 64'd0);
    check_val("rst_link_up", 64'(link_up), 64'd0);
    check_val("rst_full_duplex", 64'(full_duplex), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_val("rst_no_ack", 64'(no_ack), 64'd0);
    check_val("rst_rd_data", 64'(rd_data), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    enable = 1'b0;
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
    irq_ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_values();

    stim_q.push_back('{data: 16'hAC00, ack: 1'b1});
    stim_q.push_back('{data: 16'h0C00, ack: 1'b1});
    stim_q.push_back('{data: 16'h4C00, ack: 1'b1});
    stim_q.push_back('{data: 16'h1234, ack: 1'b0});
    stim_q.push_back('{data: 16'h8400, ack: 1'b1});
    stim_q.push_back('{data: 16'h0C00, ack: 1'b1});
    stim_q.push_back('{data: 16'hC800, ack: 1'b1});
    stim_q.push_back('{data: 16'hAC00, ack: 1'b1});
    stim_q.push_back('{data: 16'hAC00, ack: 1'b1});
    stim_q.push_back('{data: 16'h4C00, ack: 1'b1});

    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check_val("first_frame_immediate", 64'(busy), 64'd1);

    wait_frames(8, 4000);
`ifdef PHY_SPEED_MON_CHANGE_IRQ_EN
    @(posedge clk); #1 irq_ack = 1'b1;
    @(posedge clk); #1 irq_ack = 1'b0;
    @(negedge clk);
    check_val("irq_after_ack", 64'(change_irq), 64'd0);
`endif
    wait_frames(9, 1000);

    wait_rise(20, 1000);
    enable = 1'b0;
    wait_frames(10, 1000);
    n = 0;
    repeat (400) begin
      @(negedge clk);
      if (busy) n++;
    end
    check_val("idle_after_disable", 64'(n), 64'd0);

    stim_q.push_back('{data: 16'hAC00, ack: 1'b1});
    stim_q.push_back('{data: 16'h0C00, ack: 1'b1});
    enable = 1'b1;
    wait_rise(52, 1000);
    #2 reset = 1'b1;
    #1 check_reset_values();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_frames(11, 1000);

    enable = 1'b0;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy) n++;
    end
    check_val("idle_after_wait_disable", 64'(n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
